// File: rtl/ysyx_23060096_ifu.sv
// rtl/ysyx_23060096_ifu.sv - NPC instruction fetch unit: pc owner, single-outstanding imem fetch, redirect/discard
// Optional misaligned-redirect trap enabled by YSYX_23060096_IFU_MISALIGN_EN.
module ysyx_23060096_ifu #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        misalign
);

   localparam logic [31:0] BOOT_PC = RESET_PC & ~32'h3;
   localparam logic [31:0] NOP     = 32'h0000_0013;

`ifdef YSYX_23060096_IFU_MISALIGN_EN
   typedef enum logic [2:0] {ST_BOOT, ST_REQ, ST_WAIT, ST_OUT, ST_DROP, ST_HALT} state_t;
`else
   typedef enum logic [2:0] {ST_BOOT, ST_REQ, ST_WAIT, ST_OUT, ST_DROP} state_t;
`endif

   state_t      state, state_nx;
   logic [31:0] pc, pc_nx;
   logic        req_valid_nx;
   logic [31:0] req_addr_nx;
   logic        inst_valid_nx;
   logic [31:0] inst_nx;
   logic [31:0] inst_pc_nx;
   logic [31:0] target;
   logic [31:0] pc_seq;

`ifdef YSYX_23060096_IFU_MISALIGN_EN
   logic        bad_redirect;
   logic        misalign_nx;
   assign target       = redirect_pc;
   assign bad_redirect = redirect_valid && (redirect_pc[1:0] != 2'b00);
`else
   // Low address bits are ignored so the fetch address stays word aligned.
   assign target = redirect_pc & ~32'h3;
`endif

   assign pc_seq = pc + 32'd4;

   always_comb begin
      state_nx      = state;
      pc_nx         = pc;
      req_valid_nx  = imem_req_valid;
      req_addr_nx   = imem_req_addr;
      inst_valid_nx = inst_valid;
      inst_nx       = inst;
      inst_pc_nx    = inst_pc;
      case (state)
         ST_BOOT: begin
            state_nx     = ST_REQ;
            req_valid_nx = 1'b1;
            req_addr_nx  = pc;
         end
         ST_REQ: begin
            if (redirect_valid) begin
               pc_nx = target;
               if (imem_req_ready) begin
                  state_nx     = ST_DROP;
                  req_valid_nx = 1'b0;
               end else begin
                  req_addr_nx = target;
               end
            end else if (imem_req_ready) begin
               state_nx     = ST_WAIT;
               req_valid_nx = 1'b0;
            end
         end
         ST_WAIT: begin
            if (redirect_valid) begin
               pc_nx = target;
               // A response landing with the redirect is simply not captured.
               if (imem_rsp_valid) begin
                  state_nx     = ST_REQ;
                  req_valid_nx = 1'b1;
                  req_addr_nx  = target;
               end else begin
                  state_nx = ST_DROP;
               end
            end else if (imem_rsp_valid) begin
               state_nx      = ST_OUT;
               inst_valid_nx = 1'b1;
               inst_nx       = imem_rsp_data;
               inst_pc_nx    = pc;
            end
         end
         ST_OUT: begin
            if (redirect_valid || inst_ready) begin
               pc_nx         = redirect_valid ? target : pc_seq;
               state_nx      = ST_REQ;
               inst_valid_nx = 1'b0;
               req_valid_nx  = 1'b1;
               req_addr_nx   = pc_nx;
            end
         end
         ST_DROP: begin
            if (redirect_valid) begin
               pc_nx = target;
            end
            if (imem_rsp_valid) begin
               state_nx     = ST_REQ;
               req_valid_nx = 1'b1;
               req_addr_nx  = pc_nx;
            end
         end
         default: begin
            state_nx     = state;
            req_valid_nx = 1'b0;
         end
      endcase
`ifdef YSYX_23060096_IFU_MISALIGN_EN
      misalign_nx = misalign;
      if (bad_redirect && state != ST_HALT) begin
         state_nx      = ST_HALT;
         pc_nx         = pc;
         req_valid_nx  = 1'b0;
         req_addr_nx   = imem_req_addr;
         inst_valid_nx = 1'b0;
         misalign_nx   = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= ST_BOOT;
         pc             <= BOOT_PC;
         imem_req_valid <= 1'b0;
         imem_req_addr  <= BOOT_PC;
         inst_valid     <= 1'b0;
         inst           <= NOP;
         inst_pc        <= BOOT_PC;
      end else begin
         state          <= state_nx;
         pc             <= pc_nx;
         imem_req_valid <= req_valid_nx;
         imem_req_addr  <= req_addr_nx;
         inst_valid     <= inst_valid_nx;
         inst           <= inst_nx;
         inst_pc        <= inst_pc_nx;
      end
   end

`ifdef YSYX_23060096_IFU_MISALIGN_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         misalign <= 1'b0;
      end else begin
         misalign <= misalign_nx;
      end
   end
`else
   always_ff @(posedge clk) begin
      misalign <= 1'b0;
   end
`endif

endmodule
